// File: rtl/store_unit.sv
// Store path of the memory stage: turns Sb/Sh/Sw requests into full-word writes
// to a data memory without byte enables (sub-word stores use read-modify-write).
module store_unit #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [2:0]  info_store,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  localparam logic [2:0] INFO_SB   = 3'b000;
  localparam logic [2:0] INFO_SH   = 3'b001;
  localparam logic [2:0] INFO_SW   = 3'b010;
  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    ERR
  } state_t;

  state_t      state_reg;
  logic [1:0]  addr_lo_reg;
  logic [15:0] data_reg;
  logic [2:0]  info_reg;
  logic [2:0]  wait_cnt_reg;
  logic        req_bad;
  logic [31:0] merged_word;

  always_comb begin
    req_bad = 1'b1;
    case (info_store)
      INFO_SB: req_bad = 1'b0;
      INFO_SH: req_bad = req_addr[0];
      INFO_SW: req_bad = |req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  // Each byte lane either takes the store data or keeps the word just read.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       lane_hit;
      logic [7:0] lane_src;
      assign lane_hit = ((info_reg == INFO_SB) && (addr_lo_reg == LANE)) ||
                        ((info_reg == INFO_SH) && (addr_lo_reg[1] == LANE[1]));
      assign lane_src = (info_reg == INFO_SB) ? data_reg[7:0] : data_reg[8*(gi%2) +: 8];
      assign merged_word[8*gi +: 8] = lane_hit ? lane_src : mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      req_ready    <= 1'b1;
      done         <= 1'b0;
      misaligned   <= 1'b0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      wait_cnt_reg <= '0;
      addr_lo_reg  <= '0;
      data_reg     <= '0;
      info_reg     <= '0;
    end else begin
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            req_ready   <= 1'b0;
            addr_lo_reg <= req_addr[1:0];
            data_reg    <= req_data[15:0];
            info_reg    <= info_store;
            if (req_bad) begin
              state_reg  <= ERR;
              misaligned <= 1'b1;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (info_store == INFO_SW) begin
                state_reg <= WRITE;
                mem_wdata <= req_data;
                mem_we    <= 1'b1;
                done      <= 1'b1;
              end else begin
                state_reg <= READ;
                mem_re    <= 1'b1;
              end
            end
          end
        end
        READ: begin
          wait_cnt_reg <= WAIT_INIT;
          state_reg    <= WAIT;
        end
        WAIT: begin
          // Read data is only trusted in the cycle the countdown hits zero.
          if (wait_cnt_reg == 3'd0) begin
            mem_wdata <= merged_word;
            mem_we    <= 1'b1;
            done      <= 1'b1;
            state_reg <= WRITE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 3'd1;
          end
        end
        WRITE, ERR: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus randomized stores
// checked against a mask-and-shift memory model with a latency-accurate responder.
module tb_store_unit;

  localparam int RD_LAT = 3;
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [2:0]  info_store = '0;
  logic        done;
  logic        misaligned;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;
  logic        mem_we;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem [logic [31:0]];
  typedef struct {
    int          due;
    logic [31:0] addr;
  } rd_t;
  rd_t rdq[$];

  store_unit #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .info_store(info_store),
    .done(done), .misaligned(misaligned), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: valid data exactly RD_LAT cycles after mem_re, garbage otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_re === 1'b1) begin
        rd_t r;
        r.due  = cyc + RD_LAT;
        r.addr = mem_addr;
        rdq.push_back(r);
      end
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        mem_rdata = mem.exists(rdq[0].addr) ? mem[rdq[0].addr] : 32'h0;
        void'(rdq.pop_front());
      end else begin
        mem_rdata = $urandom;
      end
    end
  end

  function automatic logic ref_bad(input logic [31:0] a, input logic [2:0] i);
    case (i)
      SB:      return 1'b0;
      SH:      return a[0];
      SW:      return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] a,
                                            input logic [31:0] d, input logic [2:0] i);
    int          sh;
    logic [31:0] mask;
    if (i == SB) begin
      sh   = 8 * int'(a[1:0]);
      mask = 32'h0000_00FF << sh;
    end else begin
      sh   = 16 * int'(a[1]);
      mask = 32'h0000_FFFF << sh;
    end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] i);
    req_addr   = a;
    req_data   = d;
    info_store = i;
    req_valid  = 1'b1;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, done, misaligned, mem_re, mem_we} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 10000", {req_ready, done, misaligned, mem_re, mem_we});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got addr %h wdata %h expected 0 0", mem_addr, mem_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
    $display("txn reset done");
  endtask

  task automatic test_sw;
    issue(32'h100, 32'hDEADBEEF, SW);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({req_ready, mem_re, mem_we, done, misaligned} !== {c == 2, 1'b0, c == 1, c == 1, 1'b0}) begin
        errors++;
        $display("FAIL sw_strobes c%0d: got %b", c, {req_ready, mem_re, mem_we, done, misaligned});
      end
      if (c == 1) begin
        checks++;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL sw_write: got %h/%h expected 00000100/deadbeef", mem_addr, mem_wdata);
        end
      end
    end
    mem[32'h100] = 32'hDEADBEEF;
    $display("txn sw addr=00000100 data=deadbeef");
  endtask

  task automatic test_rmw;
    logic [31:0] ta [3] = '{32'h203, 32'h202, 32'h302};
    logic [31:0] td [3] = '{32'h0000_00AB, 32'h0000_00AB, 32'h0000_CAFE};
    logic [2:0]  ti [3] = '{SB, SB, SH};
    logic [31:0] tm [3] = '{32'h1122_3344, 32'h1122_3344, 32'h5566_7788};
    logic [31:0] tx [3] = '{32'hAB22_3344, 32'h11AB_3344, 32'hCAFE_7788};
    for (int t = 0; t < 3; t++) begin
      logic [31:0] w;
      w = {ta[t][31:2], 2'b00};
      mem[w] = tm[t];
      issue(ta[t], td[t], ti[t]);
      for (int c = 1; c <= 3 + RD_LAT; c++) begin
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({req_ready, mem_re, mem_we, done, misaligned} !==
            {c == 3 + RD_LAT, c == 1, c == 2 + RD_LAT, c == 2 + RD_LAT, 1'b0}) begin
          errors++;
          $display("FAIL rmw%0d_strobes c%0d: got %b", t, c, {req_ready, mem_re, mem_we, done, misaligned});
        end
        if (c < 3 + RD_LAT) begin
          checks++;
          if (mem_addr !== w) begin
            errors++;
            $display("FAIL rmw%0d_addr c%0d: got %h expected %h", t, c, mem_addr, w);
          end
        end
        if (c == 2 + RD_LAT) begin
          checks++;
          if (mem_wdata !== tx[t]) begin
            errors++;
            $display("FAIL rmw%0d_wdata: got %h expected %h", t, mem_wdata, tx[t]);
          end
        end
      end
      mem[w] = tx[t];
      $display("txn rmw addr=%h data=%h info=%0d expect=%h", ta[t], td[t], ti[t], tx[t]);
    end
  endtask

  task automatic test_errors;
    logic [31:0] ta [3] = '{32'h301, 32'h402, 32'h400};
    logic [2:0]  ti [3] = '{SH, SW, 3'b111};
    for (int t = 0; t < 3; t++) begin
      issue(ta[t], $urandom, ti[t]);
      for (int c = 1; c <= 2; c++) begin
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({req_ready, mem_re, mem_we, done, misaligned} !== {c == 2, 1'b0, 1'b0, 1'b0, c == 1}) begin
          errors++;
          $display("FAIL err%0d_strobes c%0d: got %b", t, c, {req_ready, mem_re, mem_we, done, misaligned});
        end
      end
      $display("txn err addr=%h info=%0d", ta[t], ti[t]);
    end
  endtask

  task automatic test_reset_mid;
    mem[32'h500] = 32'h0102_0304;
    issue(32'h501, 32'h0000_0077, SB);
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, done, misaligned, mem_re, mem_we} !== 5'b10000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b %h %h expected 10000 0 0",
               {req_ready, done, misaligned, mem_re, mem_we}, mem_addr, mem_wdata);
    end
    for (int k = 0; k < RD_LAT + 4; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      checks++;
      if (mem_we !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_quiet k%0d: got we=%b done=%b ready=%b expected 0 0 1", k, mem_we, done, req_ready);
      end
    end
    issue(32'h600, 32'h1234_5678, SW);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({req_ready, mem_we, done} !== {c == 2, c == 1, c == 1}) begin
        errors++;
        $display("FAIL rstmid_sw c%0d: got %b", c, {req_ready, mem_we, done});
      end
      if (c == 1) begin
        checks++;
        if (mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h600) begin
          errors++;
          $display("FAIL rstmid_sw_data: got %h/%h expected 00000600/12345678", mem_addr, mem_wdata);
        end
      end
    end
    mem[32'h600] = 32'h1234_5678;
    $display("txn reset_mid then sw addr=00000600");
  endtask

  task automatic test_back_to_back;
    logic [31:0] d1, d2, old, expw;
    d1 = $urandom;
    d2 = $urandom;
    mem[32'h700] = $urandom;
    old  = mem[32'h700];
    expw = ref_merge(old, 32'h701, d2, SB);
    issue(32'h704, d1, SW);
    for (int c = 1; c <= 5 + RD_LAT; c++) begin
      @(negedge clk);
      if (c == 1) issue(32'h701, d2, SB);
      if (c == 3) req_valid = 1'b0;
      checks++;
      if ({req_ready, mem_re, mem_we, done} !==
          {c == 2 || c == 5 + RD_LAT, c == 3, c == 1 || c == 4 + RD_LAT, c == 1 || c == 4 + RD_LAT}) begin
        errors++;
        $display("FAIL b2b_strobes c%0d: got %b", c, {req_ready, mem_re, mem_we, done});
      end
      if (c == 1) begin
        checks++;
        if (mem_wdata !== d1 || mem_addr !== 32'h704) begin
          errors++;
          $display("FAIL b2b_sw: got %h/%h expected 00000704/%h", mem_addr, mem_wdata, d1);
        end
      end
      if (c == 4 + RD_LAT) begin
        checks++;
        if (mem_wdata !== expw || mem_addr !== 32'h700) begin
          errors++;
          $display("FAIL b2b_sb: got %h/%h expected 00000700/%h", mem_addr, mem_wdata, expw);
        end
      end
    end
    mem[32'h704] = d1;
    mem[32'h700] = expw;
    $display("txn back_to_back sw=%h sb=%h", d1, expw);
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      logic [31:0] a, d, w, old, expw;
      logic [2:0]  i;
      logic        bad, sw;
      int          last, re_c, we_c, mis_c;
      w = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
      a = w | 32'($urandom_range(0, 3));
      d = $urandom;
      case ($urandom_range(0, 4))
        0:       i = SB;
        1:       i = SH;
        2, 3:    i = SW;
        default: i = 3'($urandom_range(3, 7));
      endcase
      if (!mem.exists(w)) mem[w] = $urandom;
      old   = mem[w];
      bad   = ref_bad(a, i);
      sw    = (i == SW);
      expw  = sw ? d : ref_merge(old, a, d, i);
      last  = (bad || sw) ? 2 : 3 + RD_LAT;
      re_c  = (!bad && !sw) ? 1 : -1;
      we_c  = bad ? -1 : (sw ? 1 : 2 + RD_LAT);
      mis_c = bad ? 1 : -1;
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d_ready: got %b expected 1", t, req_ready);
      end
      issue(a, d, i);
      for (int c = 1; c <= last; c++) begin
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({req_ready, mem_re, mem_we, done, misaligned} !==
            {c == last, c == re_c, c == we_c, c == we_c, c == mis_c}) begin
          errors++;
          $display("FAIL rnd%0d_strobes c%0d: got %b", t, c, {req_ready, mem_re, mem_we, done, misaligned});
        end
        if (!bad && c < last) begin
          checks++;
          if (mem_addr !== w) begin
            errors++;
            $display("FAIL rnd%0d_addr c%0d: got %h expected %h", t, c, mem_addr, w);
          end
        end
        if (c == we_c) begin
          checks++;
          if (mem_wdata !== expw) begin
            errors++;
            $display("FAIL rnd%0d_wdata: got %h expected %h", t, mem_wdata, expw);
          end
        end
      end
      if (!bad) mem[w] = expw;
      $display("txn rnd%0d addr=%h data=%h info=%0d bad=%0d expect=%h", t, a, d, i, bad, expw);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_rmw();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
